alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares one 4-bit ALU (add, sub, mul, div; 8-bit result, 4-bit remainder, carry and overflow flags) between two requesters. It sits between the requesters and the ALU:

- **Request side:** accepts operations on per-port valid/ready channels, granting round-robin.
- **ALU side:** drives the ALU inputs from registers, then captures the combinational result one cycle later.
- **Response side:** returns the result to the originating port on a valid/ready response channel.

---
 rtl/alu_share_arb.sv | 115 +++++++++++
 tb/tb_alu_share_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters.
// Optional ALU_SHARE_DIVZ_CNT_EN adds a saturating divide-by-zero counter.
module alu_share_arb #(
  parameter int DW = 4,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b1,
  input  logic [1:0]    req_op0,
  input  logic [1:0]    req_op1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [RW-1:0] rsp_result,
  output logic [DW-1:0] rsp_rem,
  output logic          rsp_carry,
  output logic          rsp_ovf,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  input  logic [RW-1:0] alu_result,
  input  logic [DW-1:0] alu_rem,
  input  logic          alu_carry,
  input  logic          alu_ovf,
`ifdef ALU_SHARE_DIVZ_CNT_EN
  output logic [7:0]    divz_cnt,
`endif
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       rr;
  logic       owner;
  logic       grant;
  logic       hs;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): grant = rr;
      (req_valid == 2'b10): grant = 1'b1;
      default:              grant = 1'b0;
    endcase
  end

  // ready is masked during reset so outputs sit at their reset values
  assign req_ready = (!rst && state == IDLE && |req_valid)
                   ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign rsp_valid = (state == RESP)
                   ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 2'b00;
      rsp_result <= '0;
      rsp_rem    <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            owner  <= grant;
            alu_a  <= grant ? req_a1 : req_a0;
            alu_b  <= grant ? req_b1 : req_b0;
            alu_op <= grant ? req_op1 : req_op0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_rem    <= alu_rem;
          rsp_carry  <= alu_carry;
          rsp_ovf    <= alu_ovf;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rr    <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_DIVZ_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      divz_cnt <= 8'h00;
    end else if (state == EXEC && alu_op == 2'b11
                 && alu_b == '0 && divz_cnt != 8'hFF) begin
      divz_cnt <= divz_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb.
// Includes a behavioural stand-in for the shared ALU.
module tb_alu_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_op0, req_op1;
  logic [1:0] rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_rem;
  logic       rsp_carry, rsp_ovf;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic [3:0] alu_rem;
  logic       alu_carry, alu_ovf;
  logic       busy;
`ifdef ALU_SHARE_DIVZ_CNT_EN
  logic [7:0] divz_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.DW(4), .RW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_rem(rsp_rem),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_rem(alu_rem),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf),
`ifdef ALU_SHARE_DIVZ_CNT_EN
    .divz_cnt(divz_cnt),
`endif
    .busy(busy)
  );

  // ALU stand-in: 8-bit result, remainder, borrow/ovf flags
  always_comb begin
    alu_result = 8'h00;
    alu_rem    = 4'h0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_result = {4'h0, alu_a} + {4'h0, alu_b};
        alu_ovf    = |alu_result[7:4];
      end
      2'b01: begin
        alu_result = {4'h0, alu_a} - {4'h0, alu_b};
        alu_carry  = (alu_a < alu_b);
      end
      2'b10: begin
        alu_result = {4'h0, alu_a} * {4'h0, alu_b};
        alu_ovf    = |alu_result[7:4];
      end
      default: begin
        if (alu_b == 4'h0) begin
          alu_result = 8'hFF;
          alu_rem    = 4'hF;
          alu_carry  = 1'b1;
          alu_ovf    = 1'b1;
        end else begin
          alu_result = {4'h0, alu_a / alu_b};
          alu_rem    = alu_a % alu_b;
        end
      end
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int p,
                         input logic [3:0] ea, input logic [3:0] eb,
                         input logic [1:0] eop,
                         input logic [7:0] er, input logic [3:0] erem,
                         input logic ec, input logic eo,
                         input int stall, input bit drop);
    logic [1:0] oh;
    int n;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin
      step();
      n++;
    end
    chk("accept_wait", 32'(n < 8), 32'd1);
    oh = (p == 1) ? 2'b10 : 2'b01;
    chk("req_ready_grant", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 32'd0);
    rsp_ready = (stall > 0) ? ~oh : 2'b11;
    step();
    if (drop) req_valid[p] = 1'b0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_op", 32'(alu_op), 32'(eop));
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_result", 32'(rsp_result), 32'(er));
    chk("rsp_rem", 32'(rsp_rem), 32'(erem));
    chk("rsp_carry", 32'(rsp_carry), 32'(ec));
    chk("rsp_ovf", 32'(rsp_ovf), 32'(eo));
    chk("resp_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'(oh));
      chk("hold_result", 32'(rsp_result), 32'(er));
      chk("hold_rem", 32'(rsp_rem), 32'(erem));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = (stall > 0) ? oh : 2'b11;
    step();
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("alu_a_held", 32'(alu_a), 32'(ea));
    rsp_ready = 2'b11;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_a0 = 4'h0; req_b0 = 4'h0; req_op0 = 2'b00;
    req_a1 = 4'h0; req_b1 = 4'h0; req_op1 = 2'b00;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_rem", 32'(rsp_rem), 32'd0);
    chk("rst_flags", 32'({rsp_carry, rsp_ovf}), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
`ifdef ALU_SHARE_DIVZ_CNT_EN
    chk("rst_divz", 32'(divz_cnt), 32'd0);
`endif
    rst = 1'b0;

    // add 7+9 on port 0
    req_a0 = 4'd7; req_b0 = 4'd9; req_op0 = 2'b00;
    req_valid = 2'b01;
    run_txn(0, 4'd7, 4'd9, 2'b00, 8'h10, 4'h0, 1'b0, 1'b1, 0, 1'b1);

    // both valid from reset: port 0 mul first, then port 1 sub
    do_reset();
    req_a0 = 4'd3; req_b0 = 4'd5; req_op0 = 2'b10;
    req_a1 = 4'd2; req_b1 = 4'd6; req_op1 = 2'b01;
    req_valid = 2'b11;
    run_txn(0, 4'd3, 4'd5, 2'b10, 8'h0F, 4'h0, 1'b0, 1'b0, 0, 1'b1);
    run_txn(1, 4'd2, 4'd6, 2'b01, 8'hFC, 4'h0, 1'b1, 1'b0, 0, 1'b1);

    // port 1 div 13/4 with response back-pressure
    req_a1 = 4'd13; req_b1 = 4'd4; req_op1 = 2'b11;
    req_valid = 2'b10;
    run_txn(1, 4'd13, 4'd4, 2'b11, 8'h03, 4'h1, 1'b0, 1'b0, 5, 1'b1);

    // divide by zero on port 0
    req_a0 = 4'd5; req_b0 = 4'd0; req_op0 = 2'b11;
    req_valid = 2'b01;
    run_txn(0, 4'd5, 4'd0, 2'b11, 8'hFF, 4'hF, 1'b1, 1'b1, 0, 1'b1);
`ifdef ALU_SHARE_DIVZ_CNT_EN
    chk("divz_cnt", 32'(divz_cnt), 32'd1);
`endif

    // request withdrawn before any edge
    req_valid = 2'b01;
    #1;
    chk("drop_ready", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    step();
    chk("drop_busy", 32'(busy), 32'd0);

    // rr now prefers port 1; reset lands in EXEC
    req_a0 = 4'd1; req_b0 = 4'd2; req_op0 = 2'b00;
    req_a1 = 4'd3; req_b1 = 4'd4; req_op1 = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("rr_pref1", 32'(req_ready), 32'b10);
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_result", 32'(rsp_result), 32'd0);
    chk("mid_rst_rem", 32'(rsp_rem), 32'd0);
    chk("mid_rst_flags", 32'({rsp_carry, rsp_ovf}), 32'd0);
    chk("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b01);
    run_txn(0, 4'd1, 4'd2, 2'b00, 8'h03, 4'h0, 1'b0, 1'b0, 0, 1'b1);
    run_txn(1, 4'd3, 4'd4, 2'b00, 8'h07, 4'h0, 1'b0, 1'b0, 0, 1'b1);

    // continuous contention: strict alternation
    req_a0 = 4'd1; req_b0 = 4'd1; req_op0 = 2'b00;
    req_a1 = 4'd2; req_b1 = 4'd3; req_op1 = 2'b10;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      run_txn(0, 4'd1, 4'd1, 2'b00, 8'h02, 4'h0, 1'b0, 1'b0, 0, 1'b0);
      run_txn(1, 4'd2, 4'd3, 2'b10, 8'h06, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    end
    req_valid = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
